instr_fetch_buffer: RTL

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/instr_fetch_buffer_pkg.sv | 17 +
 rtl/instr_fetch_buffer_fifo.sv | 64 ++++++
 rtl/instr_fetch_buffer.sv | 71 +++++++
 3 files changed

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: fetch step, default
// reset vector and the layout of one prefetched entry.
package instr_fetch_buffer_pkg;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; pointers carry an
// extra wrap bit so count and full/empty fall out of a plain subtraction.
module fetch_fifo
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [31:0]             wr_pc,
    input  logic [31:0]             wr_instr,
    output logic [31:0]             rd_pc,
    output logic [31:0]             rd_instr,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    fetch_entry_t head;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr[AW-1:0]] <= '{pc: wr_pc, instr: wr_instr};
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign rd_pc    = head.pc;
    assign rd_instr = head.instr;

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential prefetcher that streams instruction words into
// a small FIFO for decode, with a single-cycle flush on branch redirect.
module instr_fetch_buffer
    import instr_fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] Pc,
    input  logic [31:0] instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int unsigned CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    assign Pc        = fetch_pc;
    assign out_valid = ~empty;
    assign out_pc    = out_valid ? head_pc    : '0;
    assign out_instr = out_valid ? head_instr : '0;

    // out_ready only reaches the registered fetch_pc, never Pc directly.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push),
        .pop      (pop),
        .wr_pc    (fetch_pc),
        .wr_instr (instr),
        .rd_pc    (head_pc),
        .rd_instr (head_instr),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    count_in_range: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_C);

endmodule
